// File: rtl/qarctan_arbiter_if.sv
// Handshake/bus bundle between qarctan_arbiter, its two requester channels and the shared engine.
// Per-channel signals are 2-entry vectors indexed by channel number.
interface qarctan_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]                 ch_y_empty;
    logic [1:0]                 ch_y_rd_en;
    logic [1:0][DATA_WIDTH-1:0] ch_y_dout;
    logic [1:0]                 ch_x_empty;
    logic [1:0]                 ch_x_rd_en;
    logic [1:0][DATA_WIDTH-1:0] ch_x_dout;
    logic [1:0]                 ch_out_wr_en;
    logic [1:0]                 ch_out_full;
    logic [1:0][DATA_WIDTH-1:0] ch_out_din;

    logic                       eng_ina_empty;
    logic                       eng_ina_rd_en;
    logic [DATA_WIDTH-1:0]      eng_ina_dout;
    logic                       eng_inb_empty;
    logic                       eng_inb_rd_en;
    logic [DATA_WIDTH-1:0]      eng_inb_dout;
    logic                       eng_out_wr_en;
    logic                       eng_out_full;
    logic [DATA_WIDTH-1:0]      eng_out_din;

    logic                       proto_err;

    // Arbiter side
    modport master (
        input  ch_y_empty, ch_y_dout, ch_x_empty, ch_x_dout, ch_out_full,
        input  eng_ina_rd_en, eng_inb_rd_en, eng_out_wr_en, eng_out_din,
        output ch_y_rd_en, ch_x_rd_en, ch_out_wr_en, ch_out_din,
        output eng_ina_empty, eng_ina_dout, eng_inb_empty, eng_inb_dout, eng_out_full,
        output proto_err
    );

    // Channel FIFOs and engine side
    modport slave (
        output ch_y_empty, ch_y_dout, ch_x_empty, ch_x_dout, ch_out_full,
        output eng_ina_rd_en, eng_inb_rd_en, eng_out_wr_en, eng_out_din,
        input  ch_y_rd_en, ch_x_rd_en, ch_out_wr_en, ch_out_din,
        input  eng_ina_empty, eng_ina_dout, eng_inb_empty, eng_inb_dout, eng_out_full,
        input  proto_err
    );
endinterface

// File: rtl/qarctan_arbiter.sv
// Round-robin sharing of one qarctan engine between two channels: a one-pair input stage plus
// an in-flight tag FIFO that steers each engine result back to its owner in issue order.
module qarctan_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    qarctan_arbiter_if.master bus
);
    localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    logic                  stage_valid_q, stage_valid_d;
    logic [DATA_WIDTH-1:0] stage_y_q, stage_y_d;
    logic [DATA_WIDTH-1:0] stage_x_q, stage_x_d;
    logic [TAG_DEPTH-1:0]  tag_mem_q, tag_mem_d;
    logic [PtrW:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]         rd_ptr_q, rd_ptr_d;
    logic                  last_q, last_d;
    logic                  proto_err_q, proto_err_d;

    logic [1:0]            ready;
    logic [PtrW-1:0]       wr_idx, rd_idx;
    logic                  tag_empty, tag_full, head;
    logic                  pop, grant, gnt_ch, out_full, accept, bad_pop;

    assign ready     = ~bus.ch_y_empty & ~bus.ch_x_empty;
    assign wr_idx    = wr_ptr_q[PtrW-1:0];
    assign rd_idx    = rd_ptr_q[PtrW-1:0];
    assign tag_empty = (wr_ptr_q == rd_ptr_q);
    assign tag_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
    assign head      = tag_mem_q[rd_idx];

    assign pop      = bus.eng_ina_rd_en & bus.eng_inb_rd_en & stage_valid_q;
    assign bad_pop  = (bus.eng_ina_rd_en ^ bus.eng_inb_rd_en)
                    | ((bus.eng_ina_rd_en | bus.eng_inb_rd_en) & ~stage_valid_q);
    // Reset gates the grant so no channel FIFO is popped while the arbiter is held in reset.
    assign grant    = reset_ni & (~stage_valid_q | pop) & ~tag_full & (|ready);
    assign gnt_ch   = (&ready) ? ~last_q : ready[1];
    assign out_full = tag_empty | bus.ch_out_full[head];
    assign accept   = bus.eng_out_wr_en & ~out_full;

    always_comb begin
        bus.ch_y_rd_en   = '0;
        bus.ch_x_rd_en   = '0;
        bus.ch_out_wr_en = '0;
        bus.ch_out_din   = '0;
        if (grant) begin
            bus.ch_y_rd_en[gnt_ch] = 1'b1;
            bus.ch_x_rd_en[gnt_ch] = 1'b1;
        end
        if (accept) begin
            bus.ch_out_wr_en[head] = 1'b1;
            bus.ch_out_din[head]   = bus.eng_out_din;
        end
        bus.eng_ina_empty = ~stage_valid_q;
        bus.eng_inb_empty = ~stage_valid_q;
        bus.eng_ina_dout  = stage_y_q;
        bus.eng_inb_dout  = stage_x_q;
        bus.eng_out_full  = out_full;
        bus.proto_err     = proto_err_q;
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_y_d     = stage_y_q;
        stage_x_d     = stage_x_q;
        tag_mem_d     = tag_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        last_d        = last_q;
        proto_err_d   = proto_err_q;

        if (grant) begin
            stage_valid_d     = 1'b1;
            stage_y_d         = bus.ch_y_dout[gnt_ch];
            stage_x_d         = bus.ch_x_dout[gnt_ch];
            tag_mem_d[wr_idx] = gnt_ch;
            wr_ptr_d          = wr_ptr_q + PtrOne;
            last_d            = gnt_ch;
        end else if (pop) begin
            stage_valid_d = 1'b0;
        end

        if (accept) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        if (bad_pop || (bus.eng_out_wr_en && tag_empty)) begin
            proto_err_d = 1'b1;
        end
    end

    // last_q resets to ch1 so that ch0 wins the first contested grant.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stage_valid_q <= 1'b0;
            stage_y_q     <= '0;
            stage_x_q     <= '0;
            tag_mem_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_q        <= 1'b1;
            proto_err_q   <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_y_q     <= stage_y_d;
            stage_x_q     <= stage_x_d;
            tag_mem_q     <= tag_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_q        <= last_d;
            proto_err_q   <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_qarctan_arbiter.sv
// Self-checking bench for qarctan_arbiter: stub engine (result = y - x, one cycle after pop),
// queue-based channel FIFOs and a transaction-level reference model of grants and returns.
module tb_qarctan_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned TD = 4;

    typedef struct packed {
        logic [DW-1:0] y;
        logic [DW-1:0] x;
    } pair_t;

    typedef struct {
        logic [1:0] ye;
        logic [1:0] xe;
        logic [1:0] exp_rd;
    } vec_t;

    logic clock;
    logic reset_n;

    qarctan_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    qarctan_arbiter #(
        .DATA_WIDTH(DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clock_i (clock),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    pair_t         chq[2][$];
    logic [DW-1:0] exp_out[2][$];
    pair_t         staged[$];
    logic [DW-1:0] eng_q[$];
    bit            inflight[$];
    bit            grant_log[$];
    bit            last_gnt;
    int            delivered[2];
    bit            eng_stall;
    bit [1:0]      full_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] y, input logic [DW-1:0] x);
        pair_t p;
        p.y = y;
        p.x = x;
        chq[ch].push_back(p);
        exp_out[ch].push_back(y - x);
    endtask

    task automatic clear_model();
        for (int n = 0; n < 2; n++) begin
            chq[n].delete();
            exp_out[n].delete();
            delivered[n] = 0;
        end
        staged.delete();
        eng_q.delete();
        inflight.delete();
        grant_log.delete();
        last_gnt  = 1'b1;
        eng_stall = 1'b0;
        full_o    = 2'b00;
    endtask

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            bus.ch_y_empty[n] = (chq[n].size() == 0);
            bus.ch_x_empty[n] = (chq[n].size() == 0);
            bus.ch_y_dout[n]  = '0;
            bus.ch_x_dout[n]  = '0;
            if (chq[n].size() != 0) begin
                bus.ch_y_dout[n] = chq[n][0].y;
                bus.ch_x_dout[n] = chq[n][0].x;
            end
        end
        bus.ch_out_full   = full_o;
        bus.eng_ina_rd_en = !eng_stall && (staged.size() != 0);
        bus.eng_inb_rd_en = !eng_stall && (staged.size() != 0);
        bus.eng_out_wr_en = (eng_q.size() != 0);
        bus.eng_out_din   = (eng_q.size() != 0) ? eng_q[0] : '0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance the model.
    task automatic tick();
        bit [1:0]      rdy;
        bit            pop, can, g, gc, h, acc, efull;
        logic [1:0]    exp_rd, exp_wr;
        pair_t         p;
        logic [DW-1:0] res;
        drive();
        #1;
        for (int n = 0; n < 2; n++) rdy[n] = (chq[n].size() != 0);
        pop    = !eng_stall && (staged.size() != 0);
        can    = ((staged.size() == 0) || pop) && (inflight.size() < TD);
        g      = can && (rdy != 2'b00);
        gc     = (rdy == 2'b11) ? !last_gnt : rdy[1];
        exp_rd = g ? (2'b01 << gc) : 2'b00;
        chk("y_rd_en", bus.ch_y_rd_en, exp_rd);
        chk("x_rd_en", bus.ch_x_rd_en, exp_rd);
        chk("ina_empty", bus.eng_ina_empty, staged.size() == 0);
        chk("inb_empty", bus.eng_inb_empty, staged.size() == 0);
        if (staged.size() != 0) begin
            chk("ina_dout", bus.eng_ina_dout, staged[0].y);
            chk("inb_dout", bus.eng_inb_dout, staged[0].x);
        end
        h      = (inflight.size() != 0) ? inflight[0] : 1'b0;
        efull  = (inflight.size() == 0) || full_o[h];
        chk("eng_out_full", bus.eng_out_full, efull);
        acc    = (eng_q.size() != 0) && !efull;
        exp_wr = acc ? (2'b01 << h) : 2'b00;
        chk("ch_out_wr_en", bus.ch_out_wr_en, exp_wr);
        chk("proto_err", bus.proto_err, 1'b0);
        if (acc) begin
            chk("ch_out_din", bus.ch_out_din[h], eng_q[0]);
            chk("other_din", bus.ch_out_din[!h], '0);
            if (exp_out[h].size() != 0) chk("result_order", bus.ch_out_din[h], exp_out[h][0]);
            else chk("unexpected_result", 1, 0);
            if (exp_out[h].size() != 0) void'(exp_out[h].pop_front());
            void'(eng_q.pop_front());
            void'(inflight.pop_front());
            delivered[h]++;
        end
        if (pop) begin
            res = bus.eng_ina_dout - bus.eng_inb_dout;
            void'(staged.pop_front());
            eng_q.push_back(res);
        end
        if (g) begin
            p = chq[gc].pop_front();
            staged.push_back(p);
            inflight.push_back(gc);
            grant_log.push_back(gc);
            last_gnt = gc;
        end
        @(negedge clock);
    endtask

    task automatic drain(input int budget);
        int pending;
        for (int i = 0; i < budget; i++) begin
            pending = chq[0].size() + chq[1].size() + staged.size() + eng_q.size();
            if (pending == 0) break;
            tick();
        end
        pending = chq[0].size() + chq[1].size() + staged.size() + eng_q.size();
        chk("drain_timeout", pending, 0);
        chk("ch0_all_results", exp_out[0].size(), 0);
        chk("ch1_all_results", exp_out[1].size(), 0);
    endtask

    // Asserts reset with both channels ready and checks reset outputs; returns at a negedge.
    task automatic reset_task();
        reset_n = 1'b0;
        clear_model();
        drive();
        bus.ch_y_empty = 2'b00;
        bus.ch_x_empty = 2'b00;
        bus.eng_out_wr_en = 1'b1;
        #1;
        chk("rst_y_rd_en", bus.ch_y_rd_en, 2'b00);
        chk("rst_x_rd_en", bus.ch_x_rd_en, 2'b00);
        chk("rst_ina_empty", bus.eng_ina_empty, 1'b1);
        chk("rst_inb_empty", bus.eng_inb_empty, 1'b1);
        chk("rst_out_full", bus.eng_out_full, 1'b1);
        chk("rst_out_wr_en", bus.ch_out_wr_en, 2'b00);
        chk("rst_out_din", bus.ch_out_din, '0);
        chk("rst_ina_dout", bus.eng_ina_dout, '0);
        chk("rst_proto_err", bus.proto_err, 1'b0);
        @(negedge clock);
        drive();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        reset_n = 1'b0;
        clear_model();
        drive();

        // Single-cycle grant decisions straight out of reset (ch0 preferred when both ready)
        tbl[0] = '{ye: 2'b11, xe: 2'b11, exp_rd: 2'b00};
        tbl[1] = '{ye: 2'b10, xe: 2'b00, exp_rd: 2'b01};
        tbl[2] = '{ye: 2'b01, xe: 2'b00, exp_rd: 2'b10};
        tbl[3] = '{ye: 2'b00, xe: 2'b00, exp_rd: 2'b01};
        tbl[4] = '{ye: 2'b00, xe: 2'b01, exp_rd: 2'b10};
        tbl[5] = '{ye: 2'b00, xe: 2'b11, exp_rd: 2'b00};
        for (int i = 0; i < 6; i++) begin
            reset_task();
            bus.ch_y_empty = tbl[i].ye;
            bus.ch_x_empty = tbl[i].xe;
            #1;
            chk($sformatf("tbl%0d_y_rd_en", i), bus.ch_y_rd_en, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_x_rd_en", i), bus.ch_x_rd_en, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_out_full", i), bus.eng_out_full, 1'b1);
        end

        // ch0 only
        reset_task();
        push(0, 5, 2);
        push(0, 9, 1);
        drain(50);
        chk("ch0_only_count", delivered[0], 2);
        chk("ch0_only_ch1_none", delivered[1], 0);

        // Both channels ready every cycle: grants must alternate starting with ch0
        reset_task();
        for (int i = 0; i < 8; i++) begin
            push(0, 10 + i, 0);
            push(1, 100 + i, 0);
        end
        drain(100);
        chk("alt_grant_count", grant_log.size(), 16);
        for (int i = 0; i < 16 && i < grant_log.size(); i++) begin
            chk($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
        end

        // ch1 output full with a ch1 result at the head blocks later ch0 results
        reset_task();
        full_o = 2'b10;
        push(1, 50, 5);
        tick();
        for (int i = 0; i < 3; i++) push(0, 20 + i, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("hol_ch0_blocked", delivered[0], 0);
        chk("hol_ch1_blocked", delivered[1], 0);
        full_o = 2'b00;
        drain(50);
        chk("hol_ch0_count", delivered[0], 3);
        chk("hol_ch1_count", delivered[1], 1);

        // Engine stalls pops: only the stage fills, no further grants
        reset_task();
        eng_stall = 1'b1;
        for (int i = 0; i < 6; i++) push(0, 30 + i, 2);
        for (int i = 0; i < TD + 2; i++) tick();
        chk("stall_one_grant", grant_log.size(), 1);
        eng_stall = 1'b0;
        drain(60);

        // Outputs blocked while the engine keeps popping: tag FIFO fills to TAG_DEPTH
        reset_task();
        full_o = 2'b11;
        for (int i = 0; i < 8; i++) begin
            push(0, 200 + i, 3);
            push(1, 300 + i, 4);
        end
        for (int i = 0; i < 12; i++) tick();
        chk("tagfull_grants", grant_log.size(), TD);
        full_o = 2'b00;
        drain(100);

        // Reset with 3 tags outstanding, then clean traffic
        reset_task();
        full_o = 2'b11;
        for (int i = 0; i < 3; i++) push(0, 40 + i, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("pre_reset_outstanding", inflight.size(), 3);
        reset_task();
        push(1, 77, 7);
        push(0, 66, 6);
        drain(50);
        chk("post_reset_ch0", delivered[0], 1);
        chk("post_reset_ch1", delivered[1], 1);

        // Randomized traffic with random stalls and output back-pressure
        reset_task();
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (chq[n].size() < 6 && $urandom_range(0, 2) != 0) push(n, $urandom, $urandom);
                full_o[n] = ($urandom_range(0, 4) == 0);
            end
            eng_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        full_o    = 2'b00;
        eng_stall = 1'b0;
        drain(200);

        // Protocol errors: result write with no tag
        reset_task();
        bus.eng_out_wr_en = 1'b1;
        bus.eng_out_din   = 32'd7;
        #1;
        chk("perr_no_wr_through", bus.ch_out_wr_en, 2'b00);
        @(negedge clock);
        bus.eng_out_wr_en = 1'b0;
        #1;
        chk("perr_notag_set", bus.proto_err, 1'b1);
        repeat (3) @(negedge clock);
        #1;
        chk("perr_notag_sticky", bus.proto_err, 1'b1);

        // inA_rd_en without inB_rd_en while staged: error, stage kept
        reset_task();
        push(0, 20, 4);
        tick();
        bus.eng_ina_rd_en = 1'b1;
        bus.eng_inb_rd_en = 1'b0;
        bus.ch_y_empty    = 2'b11;
        bus.ch_x_empty    = 2'b11;
        @(negedge clock);
        bus.eng_ina_rd_en = 1'b0;
        #1;
        chk("perr_half_pop_set", bus.proto_err, 1'b1);
        chk("perr_half_pop_stage", bus.eng_ina_empty, 1'b0);
        chk("perr_half_pop_data", bus.eng_ina_dout, 32'd20);

        // Both rd_en with nothing staged
        reset_task();
        bus.eng_ina_rd_en = 1'b1;
        bus.eng_inb_rd_en = 1'b1;
        @(negedge clock);
        bus.eng_ina_rd_en = 1'b0;
        bus.eng_inb_rd_en = 1'b0;
        #1;
        chk("perr_empty_pop", bus.proto_err, 1'b1);
        reset_task();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
